// File: rtl/interconn_pkg.sv
// Shared crossbar types: the flit carried from a sending MVU to a receive port.
package interconn_pkg;

  localparam int N_MVU  = 8;
  localparam int W_WORD = 64;
  localparam int BADDR  = 15;

  typedef struct packed {
    logic [N_MVU-1:0]  src;
    logic [BADDR-1:0]  addr;
    logic [W_WORD-1:0] word;
  } ic_flit_t;

endpackage

// File: rtl/interconn_recv_port_if.sv
// Bundle of crossbar-receive, memory-write and status signals of one receive port.
interface interconn_recv_port_if #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
);
  import interconn_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_MVU-1:0]  recv_from;
  logic              recv_en;
  logic [BADDR-1:0]  recv_addr;
  logic [W_WORD-1:0] recv_word;
  logic [N_MVU-1:0]  src_mask;
  logic              mem_busy;
  logic              ovf_clr;

  logic              mem_we;
  logic [BADDR-1:0]  mem_addr;
  logic [W_WORD-1:0] mem_word;
  logic [N_MVU-1:0]  mem_src;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic [CNTW-1:0]   drop_cnt;

  modport master (
    output recv_from, recv_en, recv_addr, recv_word, src_mask, mem_busy, ovf_clr,
    input  mem_we, mem_addr, mem_word, mem_src, fifo_count, overflow, drop_cnt
  );

  modport slave (
    input  recv_from, recv_en, recv_addr, recv_word, src_mask, mem_busy, ovf_clr,
    output mem_we, mem_addr, mem_word, mem_src, fifo_count, overflow, drop_cnt
  );

endinterface

// File: rtl/interconn_fifo.sv
// Synchronous FIFO of crossbar flits; full/empty come from the occupancy count.
module interconn_fifo
  import interconn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  ic_flit_t               din,
  output ic_flit_t               dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  ic_flit_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  // Storage carries no reset; the caller never pops an empty or pushes a full FIFO.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign dout  = r_mem[r_rptr];
  assign count = r_count;

endmodule

// File: rtl/interconn_recv_port.sv
// MVU receive port: filters crossbar words by source, buffers them and drains into the data-memory write port.
module interconn_recv_port
  import interconn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  interconn_recv_port_if.slave bus
);

  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic            w_acc;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [CW-1:0]   w_count;
  ic_flit_t        w_din;
  ic_flit_t        w_head;

  logic              r_mem_we;
  logic [BADDR-1:0]  r_mem_addr;
  logic [W_WORD-1:0] r_mem_word;
  logic [N_MVU-1:0]  r_mem_src;
  logic              r_overflow;
  logic [CNTW-1:0]   r_drop_cnt;

  assign w_acc  = bus.recv_en & (|(bus.recv_from & bus.src_mask));
  assign w_pop  = (w_count != '0) & ~bus.mem_busy;
  // A full FIFO still takes the new word when its head leaves in the same cycle.
  assign w_push = w_acc & ((w_count != FULL) | w_pop);
  assign w_drop = w_acc & ~w_push;

  assign w_din = '{src: bus.recv_from, addr: bus.recv_addr, word: bus.recv_word};

  interconn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_word <= '0;
      r_mem_src  <= '0;
    end else begin
      r_mem_we <= w_pop;
      if (w_pop) begin
        r_mem_addr <= w_head.addr;
        r_mem_word <= w_head.word;
        r_mem_src  <= w_head.src;
      end
    end
  end

  // A drop in the same cycle as ovf_clr restarts the count at one.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= bus.ovf_clr ? CNTW'(1) : sat_inc(r_drop_cnt);
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_word   = r_mem_word;
  assign bus.mem_src    = r_mem_src;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_overflow;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_interconn_recv_port.sv
// Self-checking bench for interconn_recv_port: scenario tasks plus an in-order write scoreboard.
module tb_interconn_recv_port;
  import interconn_pkg::*;

  logic clk = 1'b0;
  logic clr;

  interconn_recv_port_if #(.DEPTH(4), .CNTW(16)) ifc ();

  interconn_recv_port #(.DEPTH(4), .CNTW(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_bad = 0;
  ic_flit_t exp_q[$];

  // Advance one clock and retire any memory write against the expected-order queue.
  task automatic cyc();
    ic_flit_t got;
    ic_flit_t exp;
    @(posedge clk);
    #1;
    if (ifc.mem_we === 1'b1) begin
      got = '{src: ifc.mem_src, addr: ifc.mem_addr, word: ifc.mem_word};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_write: got src=%h addr=%h word=%h, required no write",
                 got.src, got.addr, got.word);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL sb_order: got src=%h addr=%h word=%h, required src=%h addr=%h word=%h",
                   got.src, got.addr, got.word, exp.src, exp.addr, exp.word);
        end
      end
    end
  endtask

  task automatic put(input logic [7:0] from, input logic [14:0] addr,
                     input logic [63:0] word, input bit keep);
    ifc.recv_en   = 1'b1;
    ifc.recv_from = from;
    ifc.recv_addr = addr;
    ifc.recv_word = word;
    if (keep) exp_q.push_back('{src: from, addr: addr, word: word});
    cyc();
    ifc.recv_en = 1'b0;
  endtask

  task automatic test_reset();
    #7;
    n_vec++;
    if ({ifc.mem_we, ifc.mem_addr, ifc.mem_word, ifc.mem_src, ifc.fifo_count,
         ifc.overflow, ifc.drop_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%h word=%h src=%h cnt=%0d ovf=%b drop=%0d, required all 0",
               ifc.mem_we, ifc.mem_addr, ifc.mem_word, ifc.mem_src, ifc.fifo_count,
               ifc.overflow, ifc.drop_cnt);
    end
    #1 clr = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    ifc.src_mask = 8'hFF;
    ifc.mem_busy = 1'b0;
    put(8'h04, 15'h0123, 64'hDEAD_BEEF, 1'b1);
    n_vec++;
    if (ifc.fifo_count !== 3'd1 || ifc.mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL single_cycle1: got cnt=%0d we=%b, required cnt=1 we=0", ifc.fifo_count, ifc.mem_we);
    end
    cyc();
    n_vec++;
    if (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 15'h0123 || ifc.mem_word !== 64'hDEAD_BEEF ||
        ifc.mem_src !== 8'h04 || ifc.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL single_cycle2: got we=%b addr=%h word=%h src=%h cnt=%0d, required 1 0123 deadbeef 04 0",
               ifc.mem_we, ifc.mem_addr, ifc.mem_word, ifc.mem_src, ifc.fifo_count);
    end
    cyc();
    n_vec++;
    if (ifc.mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL single_cycle3: got we=%b, required 0", ifc.mem_we);
    end
  endtask

  task automatic test_mask();
    ifc.src_mask = 8'h01;
    put(8'h02, 15'h0055, 64'h1111_2222, 1'b0);
    n_vec++;
    if (ifc.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL mask_count: got %0d, required 0", ifc.fifo_count);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_vec++;
      if (ifc.mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL mask_no_write: got we=%b, required 0", ifc.mem_we);
      end
    end
    n_vec++;
    if (ifc.overflow !== 1'b0 || ifc.drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mask_no_drop: got ovf=%b drop=%0d, required 0 0", ifc.overflow, ifc.drop_cnt);
    end
    // Multi-bit source with one masked bit is accepted and reproduced unchanged.
    put(8'h03, 15'h0077, 64'h3333_4444, 1'b1);
    cyc();
    n_vec++;
    if (ifc.mem_we !== 1'b1 || ifc.mem_src !== 8'h03) begin
      n_bad++;
      $display("FAIL mask_multibit: got we=%b src=%h, required 1 03", ifc.mem_we, ifc.mem_src);
    end
    cyc();
    ifc.src_mask = 8'hFF;
  endtask

  task automatic test_overflow();
    ifc.mem_busy = 1'b1;
    for (int i = 0; i < 6; i++)
      put(8'h10, 15'(16'h0100 + i), 64'hA5A5_0000_0000_0000 + 64'(i), i < 4);
    n_vec++;
    if (ifc.fifo_count !== 3'd4 || ifc.drop_cnt !== 16'd2 || ifc.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_state: got cnt=%0d drop=%0d ovf=%b, required 4 2 1",
               ifc.fifo_count, ifc.drop_cnt, ifc.overflow);
    end
    ifc.mem_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_vec++;
      if (ifc.mem_we !== 1'b1) begin
        n_bad++;
        $display("FAIL ovf_drain_%0d: got we=%b, required 1", k, ifc.mem_we);
      end
    end
    cyc();
    n_vec++;
    if (ifc.mem_we !== 1'b0 || ifc.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL ovf_drain_end: got we=%b cnt=%0d, required 0 0", ifc.mem_we, ifc.fifo_count);
    end
    ifc.ovf_clr = 1'b1;
    cyc();
    ifc.ovf_clr = 1'b0;
    n_vec++;
    if (ifc.overflow !== 1'b0 || ifc.drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b drop=%0d, required 0 0", ifc.overflow, ifc.drop_cnt);
    end
  endtask

  task automatic test_full_pop();
    ifc.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      put(8'h20, 15'(16'h0200 + i), 64'hC0DE_0000 + 64'(i), 1'b1);
    n_vec++;
    if (ifc.fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_count: got %0d, required 4", ifc.fifo_count);
    end
    ifc.mem_busy = 1'b0;
    put(8'h40, 15'h02FF, 64'hFEED_FACE, 1'b1);
    n_vec++;
    if (ifc.fifo_count !== 3'd4 || ifc.drop_cnt !== 16'd0 || ifc.mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL full_pop_push: got cnt=%0d drop=%0d we=%b, required 4 0 1",
               ifc.fifo_count, ifc.drop_cnt, ifc.mem_we);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_vec++;
      if (ifc.mem_we !== 1'b1) begin
        n_bad++;
        $display("FAIL full_drain_%0d: got we=%b, required 1", k, ifc.mem_we);
      end
    end
    cyc();
    n_vec++;
    if (ifc.mem_we !== 1'b0 || ifc.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL full_drain_end: got we=%b cnt=%0d, required 0 0", ifc.mem_we, ifc.fifo_count);
    end
  endtask

  task automatic test_stall();
    int  peak;
    bit  exp_we;
    peak = 0;
    for (int c = 0; c < 16; c++) begin
      ifc.recv_en = (c < 10);
      if (c < 10) begin
        ifc.recv_from = 8'h01 << (c % 8);
        ifc.recv_addr = 15'(16'h0300 + c);
        ifc.recv_word = 64'h5A5A_0000 + 64'(c);
        exp_q.push_back('{src: ifc.recv_from, addr: ifc.recv_addr, word: ifc.recv_word});
      end
      ifc.mem_busy = (c == 4 || c == 5);
      cyc();
      exp_we = ((c + 1) >= 2 && (c + 1) <= 4) || ((c + 1) >= 7 && (c + 1) <= 13);
      n_vec++;
      if (ifc.mem_we !== exp_we) begin
        n_bad++;
        $display("FAIL stall_we_cycle%0d: got %b, required %b", c + 1, ifc.mem_we, exp_we);
      end
      if (int'(ifc.fifo_count) > peak) peak = int'(ifc.fifo_count);
    end
    ifc.recv_en  = 1'b0;
    ifc.mem_busy = 1'b0;
    n_vec++;
    if (peak != 3 || ifc.drop_cnt !== 16'd0 || ifc.fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL stall_summary: got peak=%0d drop=%0d cnt=%0d, required 3 0 0",
               peak, ifc.drop_cnt, ifc.fifo_count);
    end
  endtask

  task automatic test_async_reset();
    ifc.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      put(8'h08, 15'(16'h0400 + i), 64'hBAD0_0000 + 64'(i), 1'b0);
    n_vec++;
    if (ifc.fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL areset_fill: got cnt=%0d, required 3", ifc.fifo_count);
    end
    ifc.mem_busy = 1'b0;
    #2 clr = 1'b1;
    #1;
    n_vec++;
    if ({ifc.mem_we, ifc.mem_addr, ifc.mem_word, ifc.mem_src, ifc.fifo_count,
         ifc.overflow, ifc.drop_cnt} !== '0) begin
      n_bad++;
      $display("FAIL areset_immediate: got we=%b addr=%h word=%h src=%h cnt=%0d ovf=%b drop=%0d, required all 0",
               ifc.mem_we, ifc.mem_addr, ifc.mem_word, ifc.mem_src, ifc.fifo_count,
               ifc.overflow, ifc.drop_cnt);
    end
    cyc();
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_vec++;
      if (ifc.mem_we !== 1'b0 || ifc.fifo_count !== 3'd0) begin
        n_bad++;
        $display("FAIL areset_idle_%0d: got we=%b cnt=%0d, required 0 0", k, ifc.mem_we, ifc.fifo_count);
      end
    end
    put(8'h80, 15'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    cyc();
    n_vec++;
    if (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 15'h7FFF) begin
      n_bad++;
      $display("FAIL areset_resume: got we=%b addr=%h, required 1 7fff", ifc.mem_we, ifc.mem_addr);
    end
    cyc();
  endtask

  task automatic test_ovf_clr_drop();
    ifc.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      put(8'h02, 15'(16'h0500 + i), 64'h0DD0_0000 + 64'(i), 1'b1);
    put(8'h02, 15'h0504, 64'h0DD0_0004, 1'b0);
    n_vec++;
    if (ifc.drop_cnt !== 16'd1 || ifc.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL clrdrop_first: got drop=%0d ovf=%b, required 1 1", ifc.drop_cnt, ifc.overflow);
    end
    ifc.ovf_clr = 1'b1;
    put(8'h02, 15'h0505, 64'h0DD0_0005, 1'b0);
    ifc.ovf_clr = 1'b0;
    n_vec++;
    if (ifc.drop_cnt !== 16'd1 || ifc.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL clrdrop_same_cycle: got drop=%0d ovf=%b, required 1 1", ifc.drop_cnt, ifc.overflow);
    end
    ifc.ovf_clr  = 1'b1;
    ifc.mem_busy = 1'b0;
    cyc();
    ifc.ovf_clr = 1'b0;
    n_vec++;
    if (ifc.drop_cnt !== 16'd0 || ifc.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clrdrop_clear: got drop=%0d ovf=%b, required 0 0", ifc.drop_cnt, ifc.overflow);
    end
    for (int k = 0; k < 6; k++) cyc();
    n_vec++;
    if (ifc.fifo_count !== 3'd0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got cnt=%0d pending=%0d, required 0 0", ifc.fifo_count, exp_q.size());
    end
  endtask

  initial begin
    clr           = 1'b1;
    ifc.recv_en   = 1'b0;
    ifc.recv_from = '0;
    ifc.recv_addr = '0;
    ifc.recv_word = '0;
    ifc.src_mask  = '0;
    ifc.mem_busy  = 1'b0;
    ifc.ovf_clr   = 1'b0;
    test_reset();
    test_single();
    test_mask();
    test_overflow();
    test_full_pop();
    test_stall();
    test_async_reset();
    test_ovf_clr_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/interconn_recv_port.md
Name: interconn_recv_port

Overview:
- Receive-side endpoint of the MVU crossbar interconnect; one instance per MVU, fed by that MVU's recv_from/recv_en/recv_addr/recv_word.
- The crossbar has no backpressure, so a word may arrive every cycle. This block filters words by source and buffers them in a FIFO.
- It drains the FIFO into the MVU data-memory write port whenever the MVU's own datapath is not using that port.
- Words arriving with no FIFO space are dropped and counted; a sticky overflow flag is raised.

Parameters:
- N, 8, number of MVUs (width of one-hot source ID)
- W, 64, data word bitwidth
- BADDR, 15, memory address bitwidth
- DEPTH, 4, FIFO entries (power of 2, >=2)
- CNTW, 16, drop counter width

Ports:
- clk  in  1  clock
- clr  in  1  asynchronous active-high reset
- recv_from  in  N  one-hot source MVU of the incoming word
- recv_en  in  1  incoming word valid
- recv_addr  in  BADDR  target memory address
- recv_word  in  W  incoming data
- src_mask  in  N  bit i=1 accepts words from MVU i
- mem_busy  in  1  local datapath owns memory write port this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  BADDR  memory write address
- mem_word  out  W  memory write data
- mem_src  out  N  one-hot source of the word being written
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: at least one accepted-class word was dropped
- ovf_clr  in  1  synchronous clear of overflow and drop_cnt
- drop_cnt  out  CNTW  saturating count of dropped words

Behaviour:
- Reset (clr=1, asynchronous):
  - All outputs are 0: mem_we, mem_addr, mem_word, mem_src, fifo_count, overflow, drop_cnt.
  - FIFO pointers are 0.
- Accept condition: acc = recv_en & |(recv_from & src_mask).
  - recv_en with no masked source bit set: the word is silently ignored. It is not a drop.
- Pop condition, evaluated on registered state: pop = (fifo_count != 0) & ~mem_busy.
- Push condition: push = acc & ((fifo_count != DEPTH) | pop).
  - When full with a simultaneous pop, the incoming word is pushed. It is not dropped.
- Drop condition: drop = acc & ~push.
  - On drop: overflow <= 1 and drop_cnt <= drop_cnt+1, saturating at 2^CNTW-1.
- FIFO entry contents: {recv_from, recv_addr, recv_word}, stored at posedge clk.
- fifo_count update: fifo_count <= fifo_count + push - pop.
- Output registers:
  - On pop: mem_we <= 1, and mem_addr/mem_word/mem_src are loaded from the FIFO head.
  - Otherwise: mem_we <= 0, and mem_addr/mem_word/mem_src hold their previous values.
- Latency: a word presented in cycle t appears with mem_we=1 in cycle t+2 when the FIFO was empty and mem_busy=0 in cycle t+1. There is no combinational bypass.
- Throughput: one write per cycle sustained while mem_busy=0.
- Order: strict FIFO. Words from different sources are not reordered.
- mem_busy: stalls draining only. It never affects acceptance.
- ovf_clr:
  - ovf_clr=1 clears overflow and drop_cnt next edge.
  - If drop and ovf_clr occur in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full and empty are distinguished by fifo_count, not by pointer equality.
- Reset mid-operation: FIFO contents are discarded and a pending write is lost. No mem_we is asserted in the cycle after clr deasserts.
- recv_from with multiple bits set is accepted if any bit is masked. mem_src reproduces the input unchanged.

Decomposition:
- Shared package interconn_pkg holds:
  - localparam N_MVU
  - localparam W_WORD
  - localparam BADDR
  - typedef struct packed {logic [N-1:0] src; logic [BADDR-1:0] addr; logic [W-1:0] word;} ic_flit_t, which is also used by the crossbar
- One sub-module: interconn_fifo, a synchronous FIFO of ic_flit_t.
  - Parameter DEPTH.
  - Ports push, pop, din, dout, count.
  - Reset clr, asynchronous active-high.
- The top level holds the accept/drop logic, counters and output registers.

Test Plan:
- Single word: src_mask=8'hFF, recv_from=8'h04, addr=15'h0123, word=64'hDEAD_BEEF, mem_busy=0 at cycle 0 -> mem_we=1 in cycle 2 with addr 0x0123, word 0xDEADBEEF, mem_src 0x04; fifo_count=1 in cycle 1 only.
- Mask filter: src_mask=8'h01, word from recv_from=8'h02 -> no mem_we, fifo_count=0, overflow=0, drop_cnt=0.
- Overflow: mem_busy=1, 6 consecutive accepted words (DEPTH=4) -> fifo_count=4, drop_cnt=2, overflow=1; release mem_busy -> words 1-4 written in order on 4 consecutive cycles, words 5-6 never written.
- Full plus simultaneous pop: FIFO full, mem_busy drops to 0 as a new word arrives -> no drop, fifo_count stays 4, new word written 4th after the 3 older entries.
- Stall mid-stream: continuous input at 1 word/cycle, mem_busy pulsed high for 2 cycles -> mem_we gap of exactly 2 cycles, fifo_count peaks at 3, no drops, order preserved.
- Async reset: clr asserted between clock edges with 3 entries buffered -> outputs 0 immediately; after release, no mem_we until new input arrives; ovf_clr together with a drop -> overflow=1, drop_cnt=1.
